// File: rtl/serial_to_parallel_shift_in_pkg.sv
// Shared helpers for the serial shift-in deserializer: frame sizing and parity.
// The DESER_PARITY_EN macro adds a trailing even-parity bit to every frame.
package serial_shift_pkg;

    localparam int unsigned PARITY_MAX_W = 64;

    // Qualified bits per frame: data bits plus the optional parity bit.
    function automatic int unsigned frame_len(input int unsigned n);
`ifdef DESER_PARITY_EN
        return n + 1;
`else
        return n;
`endif
    endfunction

    // Smallest counter width that can index every bit of a frame (at least 1).
    function automatic int unsigned cnt_w(input int unsigned n);
        int unsigned f;
        int unsigned w;
        f = frame_len(n);
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'd1 << w) < 64'(f)) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/serial_to_parallel_shift_in_if.sv
// Bit-serial input and valid/ready word output of the shift-in deserializer.
// DESER_PARITY_EN adds the out_parity_err flag to the bundle.
interface serial_to_parallel_shift_in_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         overflow;
`ifdef DESER_PARITY_EN
    logic         out_parity_err;

    modport master (
        output in_valid, in_bit, out_ready,
        input  out_valid, out_data, overflow, out_parity_err
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output out_valid, out_data, overflow, out_parity_err
    );
`else
    modport master (
        output in_valid, in_bit, out_ready,
        input  out_valid, out_data, overflow
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output out_valid, out_data, overflow
    );
`endif
endinterface

// File: rtl/serial_to_parallel_shift_in_core.sv
// Shift register and bit counter; presents the assembled word and a done strobe
// combinationally on the edge that takes the last frame bit (DESER_PARITY_EN aware).
module serial_shift_in_core
    import serial_shift_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic         in_bit,
    output logic [N-1:0] word_c,
    output logic         done_c
);
    localparam int unsigned FRAME = frame_len(N);
    localparam int unsigned CW    = cnt_w(N);
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    logic [N-1:0]  shreg;
    logic [N-1:0]  shifted_c;
    logic [CW-1:0] cnt;
    logic          shift_en_c;

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign shifted_c = {shreg[N-2:0], in_bit};
        end else begin : g_lsb_first
            assign shifted_c = {in_bit, shreg[N-1:1]};
        end
    endgenerate

`ifdef DESER_PARITY_EN
    // The parity bit is counted but never shifted; the word is already complete.
    assign shift_en_c = in_valid && (cnt != CW'(N));
    assign word_c     = shreg;
`else
    assign shift_en_c = in_valid;
    assign word_c     = shifted_c;
`endif

    assign done_c = in_valid && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else begin
            if (shift_en_c) begin
                shreg <= shifted_c;
            end
            if (in_valid) begin
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_to_parallel_shift_in.sv
// Serial-in, parallel-out deserializer with a single valid/ready holding register.
// DESER_PARITY_EN: frames carry a trailing even-parity bit, flagged via out_parity_err.
module serial_to_parallel_shift_in
    import serial_shift_pkg::*;
#(
    parameter int unsigned N         = 8,
    parameter int unsigned MSB_FIRST = 0
) (
    input logic                        clk,
    input logic                        rst,
    serial_to_parallel_shift_in_if.slave bus
);
    logic [N-1:0] word_c;
    logic         done_c;
    logic         accept_c;

    logic [N-1:0] data_q;
    logic         valid_q;
    logic         ovf_q;

    serial_shift_in_core #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .in_valid (bus.in_valid),
        .in_bit   (bus.in_bit),
        .word_c   (word_c),
        .done_c   (done_c)
    );

    // Holding register is free if empty or being drained this very cycle.
    assign accept_c = !valid_q || bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= done_c && !accept_c;
            if (done_c && accept_c) begin
                data_q  <= word_c;
                valid_q <= 1'b1;
            end else if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef DESER_PARITY_EN
    logic perr_q;

    // Parity flag travels with the word it describes; dropped with it too.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (done_c && accept_c) begin
            perr_q <= even_parity(PARITY_MAX_W'(word_c)) != bus.in_bit;
        end
    end

    assign bus.out_parity_err = perr_q;
`endif

    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_to_parallel_shift_in.sv
// Scoreboard bench: LSB-first and MSB-first instances share one serial stream.
// Build with DESER_PARITY_EN to also exercise the parity frame.
module tb_serial_to_parallel_shift_in;

    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   ovf_l;
    int   ovf_m;

    logic [8:0] ql[$];
    logic [8:0] qm[$];

    serial_to_parallel_shift_in_if #(.N(8)) if_l ();
    serial_to_parallel_shift_in_if #(.N(8)) if_m ();

    serial_to_parallel_shift_in #(.N(8), .MSB_FIRST(0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (if_l)
    );

    serial_to_parallel_shift_in #(.N(8), .MSB_FIRST(1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    function automatic logic [8:0] act_l();
`ifdef DESER_PARITY_EN
        return {if_l.out_parity_err, if_l.out_data};
`else
        return {1'b0, if_l.out_data};
`endif
    endfunction

    function automatic logic [8:0] act_m();
`ifdef DESER_PARITY_EN
        return {if_m.out_parity_err, if_m.out_data};
`else
        return {1'b0, if_m.out_data};
`endif
    endfunction

    // Monitor: every handshake consumes the oldest expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_l.out_valid && if_l.out_ready) begin
                if (ql.size() == 0) check("sb_lsb unexpected word", 32'(if_l.out_data), 32'hffff_ffff);
                else check("sb_lsb word", 32'(act_l()), 32'(ql.pop_front()));
            end
            if (if_m.out_valid && if_m.out_ready) begin
                if (qm.size() == 0) check("sb_msb unexpected word", 32'(if_m.out_data), 32'hffff_ffff);
                else check("sb_msb word", 32'(act_m()), 32'(qm.pop_front()));
            end
            if (if_l.overflow) ovf_l++;
            if (if_m.overflow) ovf_m++;
        end
    end

    task automatic drive(input logic v, input logic b);
        if_l.in_valid = v;
        if_m.in_valid = v;
        if_l.in_bit   = b;
        if_m.in_bit   = b;
    endtask

    task automatic set_ready(input logic r);
        if_l.out_ready = r;
        if_m.out_ready = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of w is the i-th bit on the wire.
    task automatic send_frame(input logic [7:0] w, input bit gaps, input bit push,
                              input bit ready_last, input bit bad_par);
        logic last_ready;
        last_ready = 1'b0;
        if (push) begin
            ql.push_back({bad_par, w});
            qm.push_back({bad_par, rev8(w)});
        end
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) begin
                drive(1'b0, 1'b0);
                repeat ($urandom_range(1, 3)) tick();
            end
`ifndef DESER_PARITY_EN
            if (i == 7) begin
                if (push && if_l.out_ready && !ready_last) check("no early valid", 32'(if_l.out_valid), 32'd0);
                if (ready_last) set_ready(1'b1);
            end
`endif
            drive(1'b1, w[i]);
            tick();
        end
`ifdef DESER_PARITY_EN
        if (gaps) begin
            drive(1'b0, 1'b0);
            repeat ($urandom_range(1, 3)) tick();
        end
        if (push && if_l.out_ready && !ready_last) check("no early valid", 32'(if_l.out_valid), 32'd0);
        if (ready_last) set_ready(1'b1);
        drive(1'b1, (^w) ^ bad_par);
        tick();
`endif
        drive(1'b0, 1'b0);
        last_ready = ready_last;
        if (push) begin
            check("lsb valid after last bit", 32'(if_l.out_valid), 32'd1);
            check("msb valid after last bit", 32'(if_m.out_valid), 32'd1);
            check("lsb data after last bit", 32'(act_l()), 32'({bad_par, w}));
            check("msb data after last bit", 32'(act_m()), 32'({bad_par, rev8(w)}));
            if (last_ready) check("no overflow on replace", 32'(if_l.overflow), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        ovf_l = 0;
        ovf_m = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0);
        set_ready(1'b1);
        tick();
        check("reset lsb out_valid", 32'(if_l.out_valid), 32'd0);
        check("reset lsb out_data", 32'(if_l.out_data), 32'd0);
        check("reset lsb overflow", 32'(if_l.overflow), 32'd0);
        check("reset msb out_valid", 32'(if_m.out_valid), 32'd0);
        check("reset msb out_data", 32'(if_m.out_data), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame, consumer always ready.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("t1 valid drops after handshake", 32'(if_l.out_valid), 32'd0);
        check("t1 no overflow", 32'(ovf_l), 32'd0);

        // Idle gaps between bits.
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check("t2 valid drops", 32'(if_m.out_valid), 32'd0);

        // Stalled consumer: second word is dropped.
        set_ready(1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t3 overflow pulse lsb", 32'(if_l.overflow), 32'd1);
        check("t3 overflow pulse msb", 32'(if_m.overflow), 32'd1);
        check("t3 data held", 32'(if_l.out_data), 32'h11);
        tick();
        check("t3 overflow one cycle", 32'(if_l.overflow), 32'd0);
        check("t3 still valid", 32'(if_l.out_valid), 32'd1);
        set_ready(1'b1);
        tick();
        check("t3 valid after drain", 32'(if_l.out_valid), 32'd0);
        check("t3 data kept after drain", 32'(if_l.out_data), 32'h11);

        // Drain and completion on the same edge: replace without bubble.
        set_ready(1'b0);
        send_frame(8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check("t4 valid drops", 32'(if_l.out_valid), 32'd0);

        // Reset mid-frame discards the partial word.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        drive(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5 valid after reset", 32'(if_l.out_valid), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // Wire order 0,0,0,1,0,0,1,0.
        send_frame(8'h48, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t5 msb-first word", 32'(if_m.out_data), 32'h12);
        check("t5 lsb-first word", 32'(if_l.out_data), 32'h48);
        tick();

`ifdef DESER_PARITY_EN
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t6 good parity", 32'(if_l.out_parity_err), 32'd0);
        tick();
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t6 bad parity", 32'(if_l.out_parity_err), 32'd1);
        tick();
`endif

        repeat (4) tick();
        check("lsb queue drained", 32'(ql.size()), 32'd0);
        check("msb queue drained", 32'(qm.size()), 32'd0);
        check("lsb overflow count", 32'(ovf_l), 32'd1);
        check("msb overflow count", 32'(ovf_m), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_to_parallel_shift_in.md
Name: serial_to_parallel_shift_in

Overview:
- Serial-in, parallel-out deserializer: the shift-in counterpart of the team's parallel shift blocks.
- Samples one bit per qualified clock into an N-bit shift register and counts bits.
- On the Nth bit, presents the assembled word on a valid/ready output holding register.
- Sits between a bit-serial source (serial link front end, bit-banged input) and word-wide logic.

Parameters:
- N, 8, data word width in bits (N >= 2).
- MSB_FIRST, 0, 0 = first received bit lands in bit 0; 1 = first received bit lands in bit N-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_bit is sampled on this edge when high.
- in_bit  input  1  serial data bit.
- out_valid  output  1  holding register contains an unconsumed word.
- out_ready  input  1  consumer accepts the word when out_valid && out_ready.
- out_data  output  N  assembled word.
- overflow  output  1  one-cycle pulse: a completed word was dropped.
- out_parity_err  output  1  present only with DESER_PARITY_EN (see below).

Behaviour:
- Reset:
  - Shift register, bit counter, out_data, out_valid and overflow all go to 0.
  - A reset mid-word discards the partial word; the next bit after reset is bit 0 of a new frame.
- Bit counter:
  - Width $clog2(N), runs 0..N-1.
  - Advances only when in_valid is high; a cycle with in_valid low freezes both the counter and the shift register.
  - Wraps to 0 on the last bit of a frame.
- Shift rules:
  - MSB_FIRST=0: shreg <= {in_bit, shreg[N-1:1]}.
  - MSB_FIRST=1: shreg <= {shreg[N-2:0], in_bit}.
  - After N qualified bits the word is exactly shreg including the Nth bit. The assembled word (next-shreg value) goes straight to the holding register; there is no extra stage.
- Completion (in_valid && counter == N-1):
  - Latency: out_valid is high in the cycle after the edge that samples the Nth bit.
  - If out_valid is 0, or out_valid && out_ready in the same cycle: out_data <= assembled word and out_valid <= 1. This is a back-to-back replace with no bubble and no overflow.
  - If out_valid && !out_ready: the new word is dropped, out_data keeps the old word, and overflow = 1 for exactly one cycle.
- Handshake:
  - When out_valid && out_ready and no completion is in that cycle, out_valid <= 0 next cycle.
  - out_data is stable while out_valid && !out_ready.
- No input backpressure: the serial side never stalls. The counter keeps running during overflow.
- out_data keeps its last value after consumption; it is not cleared.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Frame is N+1 qualified bits and the counter runs 0..N.
  - Bit N+1 is an even-parity bit over the N data bits and is not shifted into the data.
  - Completion occurs on the parity bit.
  - out_parity_err is registered alongside out_data, meaning (^data) != parity bit, and follows the same hold/drop rules as out_data.
  - Reset value of out_parity_err is 0.
- Undefined: the port is absent, the frame is N bits, and behaviour is exactly as above.

Decomposition:
- Package serial_shift_pkg holds:
  - function cnt_w(n) returning the counter width, including the +1 frame length when parity is enabled;
  - function even_parity(word).
- One natural sub-module is serial_shift_in_core: shift register plus bit counter, outputting the assembled word and a one-cycle "done" strobe.
- The top level owns the holding register, handshake, overflow and parity flag.

Test Plan:
1. Reset, N=8, MSB_FIRST=0, out_ready=1; bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles -> one cycle after the 8th edge out_valid=1 and out_data=8'hA5; out_valid=0 the cycle after; overflow stays 0.
2. Same frame for 8'h3C (bits 0,0,1,1,1,1,0,0) with in_valid low on 1-3 random cycles between bits -> out_data=8'h3C, latency measured from the 8th qualified bit only.
3. out_ready=0; frames 8'h11 then 8'h22 -> out_data holds 8'h11, overflow pulses one cycle at the 8'h22 completion; then out_ready=1 -> one handshake, out_valid=0, out_data stays 8'h11.
4. out_valid=1 holding 8'h11, out_ready=1 in the exact cycle 8'h22 completes -> next cycle out_data=8'h22, out_valid stays 1, overflow=0.
5. 5 bits sent, rst high one cycle, then frame 8'hF0 -> out_data=8'hF0 with no residue from the partial frame. Separately, MSB_FIRST=1 with bits 0,0,0,1,0,0,1,0 -> 8'h12, whereas the same bits with MSB_FIRST=0 -> 8'h48.
6. With DESER_PARITY_EN: 8'hA5 plus parity bit 0 -> out_parity_err=0; 8'hA5 plus parity bit 1 -> out_parity_err=1; out_valid occurs one cycle after the 9th qualified bit.
